// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: walks the enabled mux channels of one sample set in
// ascending order, registers each word and hands it downstream over valid/ready.
module chan_scan_seq #(
    parameter int W_CHAN = 16,
    parameter int W_SEL  = 4,
    parameter int N_IN   = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              scan_en_in,
    input  logic [N_IN-1:0]   chan_mask_in,
    input  logic              new_data_in,
    output logic [W_SEL-1:0]  chan_select_out,
    input  logic [W_CHAN-1:0] mux_data_in,
    output logic [W_CHAN-1:0] data_out,
    output logic [W_SEL-1:0]  chan_out,
    output logic              data_valid_out,
    input  logic              data_ready_in,
    output logic              scan_done_out,
    output logic              busy_out,
    output logic              overrun_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [W_SEL-1:0]    sel_reg, sel_next;
    logic [W_CHAN-1:0]   data_reg, data_next;
    logic [W_SEL-1:0]    chan_reg, chan_next;
    logic                valid_reg, valid_next;
    logic                done_reg, done_next;
    logic                overrun_reg, overrun_next;
    logic                pending_reg, pending_next;
    logic [N_IN-1:0]     mask_reg, mask_next;

    // Latched-mask channels strictly above the one currently selected.
    logic [N_IN-1:0]     above_mask;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (W_SEL'(gi) > sel_reg);
        end
    endgenerate

    function automatic logic [W_SEL-1:0] lowest_idx(input logic [N_IN-1:0] m);
        logic [W_SEL-1:0] idx;
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = W_SEL'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        data_next    = data_reg;
        chan_next    = chan_reg;
        valid_next   = valid_reg;
        done_next    = 1'b0;
        overrun_next = overrun_reg;
        pending_next = pending_reg;
        mask_next    = mask_reg;

        // A strobe during a scan is remembered once; a second one is an overrun.
        if (state_reg != IDLE && new_data_in) begin
            if (pending_reg) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if ((new_data_in || pending_reg) && scan_en_in && (|chan_mask_in)) begin
                    mask_next    = chan_mask_in;
                    sel_next     = lowest_idx(chan_mask_in);
                    // If a pending strobe starts this scan, a fresh strobe now queues the next one.
                    pending_next = pending_reg && new_data_in;
                    state_next   = SEL;
                end
            end
            SEL: begin
                data_next  = mux_data_in;
                chan_next  = sel_reg;
                valid_next = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (valid_reg && data_ready_in) begin
                    valid_next = 1'b0;
                    if ((|above_mask) && scan_en_in) begin
                        sel_next   = lowest_idx(above_mask);
                        state_next = SEL;
                    end else begin
                        done_next  = ~(|above_mask);
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg   <= IDLE;
            sel_reg     <= '0;
            data_reg    <= '0;
            chan_reg    <= '0;
            valid_reg   <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            pending_reg <= 1'b0;
            mask_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            data_reg    <= data_next;
            chan_reg    <= chan_next;
            valid_reg   <= valid_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
        end
    end

    assign chan_select_out = sel_reg;
    assign data_out        = data_reg;
    assign chan_out        = chan_reg;
    assign data_valid_out  = valid_reg;
    assign scan_done_out   = done_reg;
    assign overrun_out     = overrun_reg;
    assign busy_out        = (state_reg != IDLE);

endmodule
